// File: rtl/vga_vertical_sync.sv
// -----------------------------------------------------------------------------
// vga_vertical_sync
//
// Vertical timing stage of the VGA chain. It watches the active-low line sync
// produced by vga_horizontal_sync, counts lines within a frame and generates
// the frame-level timing signals.
//
// A line starts at the end of the horizontal sync pulse, which is the rising
// edge of horizontal_sync. Each frame is split into four phases in this order:
// back porch, visible lines, front porch and sync. The sync phase drives
// vertical_sync low.
//
// Every register advances only on clk edges where the pixel-rate enable
// clk_25Mhz is high. Reset is synchronous and active-low, and it takes
// priority over the enable.
//
// Ports:
//   clk              system clock, shared with vga_horizontal_sync
//   rst_n            synchronous active-low reset
//   clk_25Mhz        pixel-rate enable
//   horizontal_sync  active-low line sync from vga_horizontal_sync
//   display_sync     horizontal display window from vga_horizontal_sync
//   vertical_sync    active-low frame sync (registered)
//   display_v        high during visible lines (registered)
//   video_on         display_v & display_sync (combinational)
//   line_count       current line, 0..TOTAL-1
//   row              visible row index, 0 outside the visible lines
//   frame_start      high for one enabled cycle after line_count wraps to 0
//   frame_count      [only with VGA_VERTICAL_SYNC_FRAME_COUNT_EN] 8-bit count
//                    of frames that wraps from 255 to 0
//
// Build option:
//   VGA_VERTICAL_SYNC_FRAME_COUNT_EN  adds the frame_count output and its
//                                     register
// -----------------------------------------------------------------------------
module vga_vertical_sync #(
  parameter int BACK_PROCH   = 33,
  parameter int DISPLAY_TIME = 480,
  parameter int FRONT_PROCH  = 10,
  parameter int SYNC_TIME    = 2,
  parameter int TOTAL        = 525,
  parameter int Y_WIDTH      = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_25Mhz,
  input  logic               horizontal_sync,
  input  logic               display_sync,
  output logic               vertical_sync,
  output logic               display_v,
  output logic               video_on,
  output logic [Y_WIDTH-1:0] line_count,
  output logic [Y_WIDTH-1:0] row,
`ifdef VGA_VERTICAL_SYNC_FRAME_COUNT_EN
  output logic               frame_start,
  output logic [7:0]         frame_count
`else
  output logic               frame_start
`endif
);

  // Phase encoding.
  localparam logic [1:0] ST_BACK    = 2'd0;
  localparam logic [1:0] ST_DISPLAY = 2'd1;
  localparam logic [1:0] ST_FRONT   = 2'd2;
  localparam logic [1:0] ST_SYNC    = 2'd3;

  // These are the first line of each phase after back porch, and the last
  // line of the frame.
  localparam logic [Y_WIDTH-1:0] START_DISPLAY = Y_WIDTH'(BACK_PROCH);
  localparam logic [Y_WIDTH-1:0] START_FRONT   = Y_WIDTH'(BACK_PROCH + DISPLAY_TIME);
  localparam logic [Y_WIDTH-1:0] START_SYNC    = Y_WIDTH'(BACK_PROCH + DISPLAY_TIME + FRONT_PROCH);
  localparam logic [Y_WIDTH-1:0] LAST_LINE     = Y_WIDTH'(TOTAL - 1);

  // An inconsistent configuration is reported while the design elaborates.
  // The counter still wraps at TOTAL-1.
  if (TOTAL != BACK_PROCH + DISPLAY_TIME + FRONT_PROCH + SYNC_TIME) begin : g_cfg_check
    $error("vga_vertical_sync: TOTAL does not equal the sum of the phase lengths");
  end

  logic               hs_q;
  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic               line_tick;
  logic               wrap;
  logic [Y_WIDTH-1:0] count_nxt;
  logic [Y_WIDTH-1:0] row_nxt;

  // A new line begins when horizontal_sync rises, which is the end of the
  // sync pulse. hs_q advances only on enabled edges. So a rise that happens
  // while the enable is low is still seen at the next enabled edge.
  always_comb begin
    line_tick = horizontal_sync & ~hs_q;
    wrap      = line_tick && (line_count == LAST_LINE);
    count_nxt = line_count;
    if (line_tick) begin
      count_nxt = wrap ? '0 : line_count + 1'b1;
    end
  end

  // The phase sequence is BACK -> DISPLAY -> FRONT -> SYNC -> BACK.
  // A phase moves forward only on a line tick, and only when the next line
  // reaches the boundary of the next phase. A wrap always returns the phase
  // to BACK, so a frame with a short TOTAL still restarts cleanly.
  always_comb begin
    state_nxt = state;
    if (line_tick) begin
      case (state)
        ST_BACK:    if (count_nxt == START_DISPLAY) state_nxt = ST_DISPLAY;
        ST_DISPLAY: if (count_nxt == START_FRONT)   state_nxt = ST_FRONT;
        ST_FRONT:   if (count_nxt == START_SYNC)    state_nxt = ST_SYNC;
        default:    state_nxt = state;
      endcase
      if (wrap) begin
        state_nxt = ST_BACK;
      end
    end
  end

  // The visible row index is taken from the next line value. This keeps row
  // aligned with line_count and display_v.
  always_comb begin
    row_nxt = '0;
    if (state_nxt == ST_DISPLAY) begin
      row_nxt = count_nxt - START_DISPLAY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_q          <= 1'b1;
      line_count    <= '0;
      state         <= ST_BACK;
      vertical_sync <= 1'b1;
      display_v     <= 1'b0;
      row           <= '0;
      frame_start   <= 1'b0;
    end else if (clk_25Mhz) begin
      hs_q          <= horizontal_sync;
      line_count    <= count_nxt;
      state         <= state_nxt;
      vertical_sync <= (state_nxt != ST_SYNC);
      display_v     <= (state_nxt == ST_DISPLAY);
      row           <= row_nxt;
      frame_start   <= wrap;
    end
  end

`ifdef VGA_VERTICAL_SYNC_FRAME_COUNT_EN
  // frame_count steps on the same edge that raises frame_start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_count <= 8'd0;
    end else if (clk_25Mhz && wrap) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`endif

  assign video_on = display_v & display_sync;

endmodule

// File: tb/tb_vga_vertical_sync.sv
// -----------------------------------------------------------------------------
// tb_vga_vertical_sync
//
// This bench has two instances:
//   dut    uses a small frame: 2 back porch lines, 4 visible lines,
//          1 front porch line and 1 sync line, so 8 lines per frame.
//   dut_d  uses the default 525-line timing. A short two-cycle line drives it.
//
// Inputs are driven 1 time unit after the rising edge of clk. Outputs are
// sampled at that same point.
// -----------------------------------------------------------------------------
module tb_vga_vertical_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       hs;
  logic       ds;
  logic       hs_d;
  logic       ds_d;

  logic       vs, dv, vo, fs;
  logic [9:0] lc, rw;
  logic       vs_d, dv_d, vo_d, fs_d;
  logic [9:0] lc_d, rw_d;
`ifdef VGA_VERTICAL_SYNC_FRAME_COUNT_EN
  logic [7:0] fc, fc_d;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_vertical_sync #(
    .BACK_PROCH(2), .DISPLAY_TIME(4), .FRONT_PROCH(1), .SYNC_TIME(1),
    .TOTAL(8), .Y_WIDTH(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_25Mhz(en),
    .horizontal_sync(hs), .display_sync(ds),
    .vertical_sync(vs), .display_v(dv), .video_on(vo),
    .line_count(lc), .row(rw),
`ifdef VGA_VERTICAL_SYNC_FRAME_COUNT_EN
    .frame_start(fs), .frame_count(fc)
`else
    .frame_start(fs)
`endif
  );

  vga_vertical_sync dut_d (
    .clk(clk), .rst_n(rst_n), .clk_25Mhz(en),
    .horizontal_sync(hs_d), .display_sync(ds_d),
    .vertical_sync(vs_d), .display_v(dv_d), .video_on(vo_d),
    .line_count(lc_d), .row(rw_d),
`ifdef VGA_VERTICAL_SYNC_FRAME_COUNT_EN
    .frame_start(fs_d), .frame_count(fc_d)
`else
    .frame_start(fs_d)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // This task makes one line on the small instance. It holds horizontal_sync
  // low for one enabled cycle, then high, which gives a rising edge.
  task automatic line_pulse();
    hs = 1'b0;
    step();
    hs = 1'b1;
    step();
  endtask

  initial begin
    int l;
    int vs_low, vo_hi, fs_hi, fs_c0, fs_c1, cyc, max_l;
    rst_n = 1'b0; en = 1'b1; hs = 1'b1; ds = 1'b1; hs_d = 1'b1; ds_d = 1'b0;

    // Hold reset for 3 cycles while horizontal_sync toggles.
    for (int i = 0; i < 3; i++) begin
      hs = ~hs;
      step();
    end
    check("rst_line_count", lc, 0);
    check("rst_vertical_sync", vs, 1);
    check("rst_display_v", dv, 0);
    check("rst_row", rw, 0);
    check("rst_frame_start", fs, 0);
    check("rst_video_on", vo, 0);

    // Release reset with horizontal_sync high. This must not count a line.
    hs = 1'b1;
    rst_n = 1'b1;
    step();
    check("release_no_tick", lc, 0);

    // Run one frame of the small configuration.
    for (int i = 1; i <= 8; i++) begin
      line_pulse();
      l = i % 8;
      check($sformatf("frame_line_%0d", i), lc, l);
      check($sformatf("frame_dv_%0d", i), dv, (l >= 2 && l <= 5) ? 1 : 0);
      check($sformatf("frame_row_%0d", i), rw, (l >= 2 && l <= 5) ? l - 2 : 0);
      check($sformatf("frame_vs_%0d", i), vs, (l == 7) ? 0 : 1);
      check($sformatf("frame_fs_%0d", i), fs, (i == 8) ? 1 : 0);
    end
`ifdef VGA_VERTICAL_SYNC_FRAME_COUNT_EN
    check("frame_count_1", fc, 1);
`endif
    step();
    check("fs_one_cycle", fs, 0);
    check("wrap_hold_line", lc, 0);
`ifdef VGA_VERTICAL_SYNC_FRAME_COUNT_EN
    for (int f = 0; f < 255; f++) begin
      for (int i = 0; i < 8; i++) line_pulse();
    end
    check("frame_count_wrap", fc, 0);
    check("frame_count_wrap_line", lc, 0);
`endif

    // A held level must not count. Low then high gives exactly one line.
    hs = 1'b0;
    for (int i = 0; i < 50; i++) step();
    check("held_low", lc, 0);
    hs = 1'b1;
    for (int i = 0; i < 50; i++) step();
    check("held_high_one_inc", lc, 1);

    // A rising edge while the enable is low is counted at the next enabled
    // cycle.
    hs = 1'b0;
    step();
    en = 1'b0;
    hs = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("gated_no_count", lc, 1);
    en = 1'b1;
    step();
    check("gated_counted", lc, 2);
    check("gated_dv", dv, 1);

    // Reset in the middle of the frame at line 5.
    for (int i = 0; i < 3; i++) line_pulse();
    check("pre_rst_line5", lc, 5);
    check("pre_rst_row3", rw, 3);
    rst_n = 1'b0;
    hs = 1'b1;
    step();
    check("mid_rst_line", lc, 0);
    check("mid_rst_dv", dv, 0);
    check("mid_rst_vs", vs, 1);
    check("mid_rst_row", rw, 0);
    rst_n = 1'b1;
    step();
    step();
    check("mid_rst_no_spurious", lc, 0);
    line_pulse();
    check("mid_rst_resume", lc, 1);

    // Run two frames of the default configuration. Each line lasts two cycles,
    // and display_sync is high in the second cycle of each line.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vs_low = 0; vo_hi = 0; fs_hi = 0; fs_c0 = -1; fs_c1 = -1; cyc = 0; max_l = 0;
    for (int i = 1; i <= 1050; i++) begin
      hs_d = 1'b0; ds_d = 1'b0;
      step(); cyc++;
      if (i <= 525 && !vs_d) vs_low++;
      if (vo_d) vo_hi++;
      if (fs_d) fs_hi++;
      hs_d = 1'b1; ds_d = 1'b1;
      step(); cyc++;
      if (i <= 525 && !vs_d) vs_low++;
      if (i <= 525 && vo_d) vo_hi++;
      if (fs_d) begin
        fs_hi++;
        if (fs_c0 < 0) fs_c0 = cyc; else fs_c1 = cyc;
      end
      if (int'(lc_d) > max_l) max_l = int'(lc_d);
    end
    check("dflt_vs_low_cycles", vs_low, 4);
    check("dflt_video_on_lines", vo_hi, 480);
    check("dflt_fs_count", fs_hi, 2);
    check("dflt_fs_first", fs_c0, 1050);
    check("dflt_fs_period", fs_c1 - fs_c0, 1050);
    check("dflt_max_line", max_l, 524);
    check("dflt_end_line", lc_d, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_vertical_sync.md
Name: vga_vertical_sync

Overview:
- Downstream stage of vga_horizontal_sync in the VGA timing chain.
- Detects line boundaries from the horizontal sync output and counts lines per frame.
- Generates the active-low vertical sync, the vertical display window, the visible row index and a frame-start pulse.
- Combines both display windows into video_on for the pixel generator.

Parameters:
- BACK_PROCH, 33: lines of vertical back porch (phase 0 of each frame).
- DISPLAY_TIME, 480: visible lines.
- FRONT_PROCH, 10: lines of front porch.
- SYNC_TIME, 2: lines of vertical sync pulse.
- TOTAL, 525: lines per frame; must equal the sum of the four above.
- Y_WIDTH, 10: width of line_count and row.

Ports:
- clk  input  1  system clock, same clock as vga_horizontal_sync.
- rst_n  input  1  synchronous active-low reset.
- clk_25Mhz  input  1  pixel-rate enable from vga_clk_25Mhz.
- horizontal_sync  input  1  active-low line sync from vga_horizontal_sync.
- display_sync  input  1  horizontal display window from vga_horizontal_sync.
- vertical_sync  output  1  active-low frame sync.
- display_v  output  1  high during visible lines.
- video_on  output  1  display_v AND display_sync (combinational).
- line_count  output  Y_WIDTH  current line, 0..TOTAL-1.
- row  output  Y_WIDTH  visible row index; 0 outside the display window.
- frame_start  output  1  one-clk pulse when line_count wraps to 0.

Behaviour:
- Single clock: clk, one domain. Reset is synchronous, active-low, sampled on the clk rising edge.
- Update enable: all registers update only on clk edges where clk_25Mhz=1; otherwise hold. Reset overrides the enable.
- Edge detect: hs_q holds the last sampled horizontal_sync. line_tick = horizontal_sync & ~hs_q, i.e. the end of the h-sync pulse, which starts a new line. Falling edges are ignored.
- Counter: on line_tick, line_count <= (line_count == TOTAL-1) ? 0 : line_count+1.
- Phase FSM, states BACK, DISPLAY, FRONT, SYNC:
  - BACK: line_count < BACK_PROCH.
  - DISPLAY: line_count < BACK_PROCH+DISPLAY_TIME.
  - FRONT: line_count < BACK_PROCH+DISPLAY_TIME+FRONT_PROCH.
  - SYNC: otherwise.
  - Transitions occur only on line_tick, in that order, with SYNC returning to BACK on wrap.
- Registered outputs, updated on the same edge as line_count:
  - vertical_sync = 0 in SYNC, else 1.
  - display_v = 1 in DISPLAY, else 0.
  - row = line_count - BACK_PROCH in DISPLAY, else 0.
- frame_start: 1 for exactly one enabled cycle following the edge that wrapped TOTAL-1 to 0. It is not asserted by reset.
- Reset values: line_count=0, state=BACK, vertical_sync=1, display_v=0, row=0, frame_start=0, hs_q=1. Because hs_q resets to 1, a horizontal_sync that is high at reset release does not produce a tick.
- Reset mid-frame: all registers return to their reset values on the next clk edge. Counting resumes at the first rising edge after release.
- Held input: horizontal_sync constant for any duration gives no tick and no change.
- Configuration check: if TOTAL differs from the phase sum, a simulation-only $error is raised at elaboration. The counter still wraps at TOTAL-1.

Optional Feature:
- Macro: VGA_VERTICAL_SYNC_FRAME_COUNT_EN.
- Defined: adds output frame_count [7:0]. It resets to 0, increments on every enabled edge that asserts frame_start, and wraps 255 to 0.
- Not defined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 3 clk while horizontal_sync toggles -> line_count=0, vertical_sync=1, display_v=0, row=0, frame_start=0, no counting.
- Small config (BACK=2, DISPLAY=4, FRONT=1, SYNC=1, TOTAL=8), 8 h-sync rising edges -> line_count 1..7 then 0; display_v high for lines 2..5 with row 0..3; vertical_sync low only at line 7.
- Wrap in the same config -> 8th edge sets line_count=0 and frame_start is high exactly one enabled cycle. With VGA_VERTICAL_SYNC_FRAME_COUNT_EN defined, frame_count goes 0 -> 1, and 256 frames return it to 0.
- Edge rules: horizontal_sync held low for 50 cycles, then high for 50 cycles -> exactly one increment. A rising edge while clk_25Mhz=0 is counted only at the next enabled cycle.
- Mid-frame reset at line 5 in the small config -> next edge line_count=0, display_v=0, vertical_sync=1. horizontal_sync high at release gives no spurious tick.
- Integration with vga_clk_25Mhz and vga_horizontal_sync at default parameters -> 525 lines per frame, vertical_sync low for 2 lines (1600 pixel ticks), frame_start period 420000 enabled cycles, video_on high for 640x480 pixels per frame.
